// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//   Capture stage behind the single-cycle 16-bit ALU. Each accepted result
//   word, its opcode and its carry/zero/sign flags go into a DEPTH-entry
//   FIFO. The consumer reads them over a valid/ready handshake, and the
//   stage also keeps sticky flag summaries.
//
// Handshake semantics, both sides:
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer holds its payload until that edge. inReady depends
//   only on occupancy and reset, never on outReady, so a full buffer refuses
//   a push even in a cycle that pops. out* is held stable while
//   outValid & !outReady.
//
// Ports
//   clk, rstN            clock; synchronous active-low reset
//   inValid/inReady      ALU-side handshake
//   inOpcode/inResult    entry payload, stored verbatim
//   inCarry/inZero/inSign
//   outValid/outReady    consumer-side handshake
//   out*                 head entry, read from registered storage (no bypass)
//   clearSticky          clears stickyFlags and zeroErr; a same-cycle push
//                        that sets a bit wins
//   stickyFlags          {carry, zero, sign} sticky summary of pushes
//   zeroErr              sticky: a pushed inZero disagreed with inResult==0
//   count                occupied entries
// ---------------------------------------------------------------------------
module alu_result_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     inValid,
   output logic                     inReady,
   input  logic [3:0]               inOpcode,
   input  logic [WIDTH-1:0]         inResult,
   input  logic                     inCarry,
   input  logic                     inZero,
   input  logic                     inSign,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [3:0]               outOpcode,
   output logic [WIDTH-1:0]         outResult,
   output logic                     outCarry,
   output logic                     outZero,
   output logic                     outSign,
   input  logic                     clearSticky,
   output logic [2:0]               stickyFlags,
   output logic                     zeroErr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = WIDTH + 7;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic [2:0]    sticky_nxt;
   logic          zero_err_nxt;

   assign inReady  = rstN & (count < DEPTH_C);
   assign outValid = (count != '0);
   assign push     = inValid & inReady;
   assign pop      = outValid & outReady;

   // Head entry comes straight from storage. Storage is cleared on reset,
   // so out* reads zero after reset.
   always_comb begin
      {outOpcode, outResult, outCarry, outZero, outSign} = mem[rd_ptr];
   end

   // The clear is applied first and the push sets are ORed in afterwards,
   // so a bit set by a same-cycle push survives clearSticky.
   always_comb begin
      sticky_nxt   = clearSticky ? 3'b000 : stickyFlags;
      zero_err_nxt = clearSticky ? 1'b0 : zeroErr;
      if (push) begin
         // Carry is meaningful only for arithmetic ops (ADD=0, SUB=1).
         if (inOpcode == 4'd0 || inOpcode == 4'd1) begin
            sticky_nxt[2] = sticky_nxt[2] | inCarry;
         end
         sticky_nxt[1] = sticky_nxt[1] | inZero;
         sticky_nxt[0] = sticky_nxt[0] | inSign;
         zero_err_nxt  = zero_err_nxt | (inZero ^ (inResult == '0));
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         stickyFlags <= 3'b000;
         zeroErr     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         stickyFlags <= sticky_nxt;
         zeroErr     <= zero_err_nxt;
         if (push) begin
            mem[wr_ptr] <= {inOpcode, inResult, inCarry, inZero, inSign};
            // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         // A push needs count < DEPTH and a pop needs count != 0, so count
         // cannot overflow or underflow.
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
